uart_bus_bridge: RTL and testbench



---
 rtl/uart_bus_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART-to-peripheral-bus bridge: 8N1 command frames become single bus reads/writes,
// answered over UART with read data or an ACK/NAK byte.
module uart_bus_bridge #(
  parameter int unsigned CLOCK_SCALE_BITS = 16,
  parameter logic [31:0] FRAME_TIMEOUT    = 32'd1000000,
  parameter logic [15:0] BUS_TIMEOUT      = 16'd1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic                        uart_rx,
  output logic                        uart_tx,
  output logic                        peripheralEnable,
  output logic                        peripheralBus_we,
  output logic                        peripheralBus_oe,
  input  logic                        peripheralBus_busy,
  output logic [15:0]                 peripheralBus_address,
  output logic [3:0]                  peripheralBus_byteSelect,
  output logic [31:0]                 peripheralBus_dataWrite,
  input  logic [31:0]                 peripheralBus_dataRead,
  output logic                        active
);

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, ACCESS, TX_RESP, DRAIN} state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rxState_e;

  state_e                      state_q, state_d;
  rxState_e                    rxState_q;
  logic [1:0]                  rxSync_q;
  logic                        rxLine;
  logic [CLOCK_SCALE_BITS-1:0] rxCnt_q, txCnt_q;
  logic [2:0]                  rxBit_q;
  logic [7:0]                  rxShift_q;
  logic                        rxValid_q;
  logic                        txLine_q, txBusy_q, txStart;
  logic [3:0]                  txBit_q;
  logic [8:0]                  txShift_q;
  logic [7:0]                  txByte;
  logic                        cmdWrite_q;
  logic [3:0]                  bsel_q;
  logic [15:0]                 addr_q;
  logic [31:0]                 data_q, frameCnt_q, respBuf_q;
  logic [1:0]                  byteCnt_q;
  logic [15:0]                 busyCnt_q;
  logic [2:0]                  respCnt_q;
  logic                        abort_q;
  logic                        badCmd, frameExpired, busTimeout, accessDone, inRx, inAccess;

  // A disabled bridge sees an idle line, so no partial byte can start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rxSync_q <= 2'b11;
    else      rxSync_q <= {rxSync_q[0], enable ? uart_rx : 1'b1};
  end
  assign rxLine = rxSync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxValid_q <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (!rxLine) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt_q == (cyclesPerBit >> 1)) begin
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxState_q <= rxLine ? RX_IDLE : RX_BITS;
          end else rxCnt_q <= rxCnt_q + 1'b1;
        end
        RX_BITS: begin
          if (rxCnt_q == cyclesPerBit) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxLine, rxShift_q[7:1]};
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
            else                 rxBit_q   <= rxBit_q + 1'b1;
          end else rxCnt_q <= rxCnt_q + 1'b1;
        end
        RX_STOP: begin
          if (rxCnt_q == cyclesPerBit) begin
            rxCnt_q   <= '0;
            rxValid_q <= rxLine;
            rxState_q <= RX_IDLE;
          end else rxCnt_q <= rxCnt_q + 1'b1;
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: bit index 0 is the start bit, 9 the stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txLine_q  <= 1'b1;
      txBusy_q  <= 1'b0;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
    end else if (!txBusy_q) begin
      if (txStart) begin
        txShift_q <= {1'b1, txByte};
        txLine_q  <= 1'b0;
        txCnt_q   <= '0;
        txBit_q   <= '0;
        txBusy_q  <= 1'b1;
      end
    end else if (txCnt_q == cyclesPerBit) begin
      txCnt_q <= '0;
      if (txBit_q == 4'd9) txBusy_q <= 1'b0;
      else begin
        txLine_q  <= txShift_q[0];
        txShift_q <= {1'b1, txShift_q[8:1]};
        txBit_q   <= txBit_q + 1'b1;
      end
    end else txCnt_q <= txCnt_q + 1'b1;
  end
  assign uart_tx = txLine_q;

  assign badCmd       = |rxShift_q[6:4];
  assign inRx         = (state_q == RX_ADDR) || (state_q == RX_DATA);
  assign inAccess     = (state_q == ACCESS);
  assign frameExpired = frameCnt_q >= (FRAME_TIMEOUT - 32'd1);
  assign busTimeout   = peripheralBus_busy && (busyCnt_q >= (BUS_TIMEOUT - 16'd1));
  assign accessDone   = !peripheralBus_busy || busTimeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && rxValid_q) state_d = badCmd ? TX_RESP : RX_ADDR;
      RX_ADDR: begin
        if (!enable || frameExpired)        state_d = IDLE;
        else if (rxValid_q && byteCnt_q[0]) state_d = cmdWrite_q ? RX_DATA : ACCESS;
      end
      RX_DATA: begin
        if (!enable || frameExpired)                state_d = IDLE;
        else if (rxValid_q && byteCnt_q == 2'd3)    state_d = ACCESS;
      end
      ACCESS:  if (accessDone) state_d = (abort_q || !enable) ? IDLE : TX_RESP;
      TX_RESP: if (!enable || respCnt_q == 3'd0) state_d = DRAIN;
      DRAIN:   if (!txBusy_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode from the state register so an async reset drops them at once.
  always_comb begin
    peripheralEnable         = inAccess;
    peripheralBus_we         = inAccess && cmdWrite_q;
    peripheralBus_oe         = inAccess && !cmdWrite_q;
    peripheralBus_address    = inAccess ? addr_q : 16'h0;
    peripheralBus_byteSelect = inAccess ? bsel_q : 4'h0;
    peripheralBus_dataWrite  = (inAccess && cmdWrite_q) ? data_q : 32'h0;
    txStart                  = (state_q == TX_RESP) && enable && (respCnt_q != 3'd0) && !txBusy_q;
    txByte                   = respBuf_q[31:24];
    active                   = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmdWrite_q <= 1'b0;
      bsel_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byteCnt_q  <= '0;
      frameCnt_q <= '0;
      busyCnt_q  <= '0;
      respBuf_q  <= '0;
      respCnt_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      frameCnt_q <= (inRx && !rxValid_q) ? frameCnt_q + 32'd1 : 32'd0;
      busyCnt_q  <= (inAccess && peripheralBus_busy)
                    ? ((busyCnt_q == 16'hFFFF) ? busyCnt_q : busyCnt_q + 16'd1) : 16'd0;
      abort_q    <= inAccess && (abort_q || !enable);
      case (state_q)
        IDLE: begin
          if (enable && rxValid_q) begin
            cmdWrite_q <= rxShift_q[7];
            bsel_q     <= rxShift_q[3:0];
            byteCnt_q  <= '0;
            if (badCmd) begin
              respBuf_q <= {NAK, 24'h0};
              respCnt_q <= 3'd1;
            end
          end
        end
        RX_ADDR: begin
          if (rxValid_q) begin
            addr_q    <= {addr_q[7:0], rxShift_q};
            byteCnt_q <= byteCnt_q[0] ? 2'd0 : 2'd1;
          end
        end
        RX_DATA: begin
          if (rxValid_q) begin
            data_q    <= {data_q[23:0], rxShift_q};
            byteCnt_q <= byteCnt_q + 2'd1;
          end
        end
        ACCESS: begin
          if (accessDone) begin
            if (busTimeout) begin
              respBuf_q <= {NAK, 24'h0};
              respCnt_q <= 3'd1;
            end else if (cmdWrite_q) begin
              respBuf_q <= {ACK, 24'h0};
              respCnt_q <= 3'd1;
            end else begin
              respBuf_q <= peripheralBus_dataRead;
              respCnt_q <= 3'd4;
            end
          end
        end
        TX_RESP: begin
          if (txStart) begin
            respBuf_q <= {respBuf_q[23:0], 8'h00};
            respCnt_q <= respCnt_q - 3'd1;
          end
        end
        DRAIN:   respCnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: drives UART command frames, models a bus
// responder, decodes the UART reply stream and checks bus activity per frame.
module tb_uart_bus_bridge;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] cyclesPerBit = 16'd15;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        peripheralEnable, peripheralBus_we, peripheralBus_oe, peripheralBus_busy;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite, peripheralBus_dataRead;
  logic        active;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_bus_bridge #(
    .CLOCK_SCALE_BITS(16),
    .FRAME_TIMEOUT(32'd3000),
    .BUS_TIMEOUT(16'd1024)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cyclesPerBit(cyclesPerBit),
    .uart_rx(uart_rx), .uart_tx(uart_tx),
    .peripheralEnable(peripheralEnable),
    .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
    .peripheralBus_busy(peripheralBus_busy),
    .peripheralBus_address(peripheralBus_address),
    .peripheralBus_byteSelect(peripheralBus_byteSelect),
    .peripheralBus_dataWrite(peripheralBus_dataWrite),
    .peripheralBus_dataRead(peripheralBus_dataRead),
    .active(active)
  );

  // Responder: busy for the first busyHold cycles of an access (or forever when forced);
  // read data is only valid in the cycle busy is low.
  logic        busyForce = 1'b0;
  int          busyHold = 0;
  logic [31:0] rdData = 32'h0;
  int          runLen = 0;

  always @(posedge clk) runLen <= peripheralEnable ? runLen + 1 : 0;
  assign peripheralBus_busy     = busyForce | (peripheralEnable && (runLen < busyHold));
  assign peripheralBus_dataRead = (peripheralEnable && !peripheralBus_busy) ? rdData : 32'hDEAD_DEAD;

  // Bus monitor: snapshot of the latest access plus running totals.
  int          accCycles = 0, unstable = 0, lastLen = 0;
  logic        capWe = 1'b0, capOe = 1'b0;
  logic [15:0] capAddr = '0;
  logic [3:0]  capBsel = '0;
  logic [31:0] capDw = '0;

  always @(negedge clk) begin
    if (peripheralEnable) begin
      accCycles <= accCycles + 1;
      lastLen   <= runLen + 1;
      if (runLen != 0 &&
          {peripheralBus_we, peripheralBus_oe, peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite}
          != {capWe, capOe, capAddr, capBsel, capDw})
        unstable <= unstable + 1;
      capWe   <= peripheralBus_we;
      capOe   <= peripheralBus_oe;
      capAddr <= peripheralBus_address;
      capBsel <= peripheralBus_byteSelect;
      capDw   <= peripheralBus_dataWrite;
    end
  end

  // UART reply decoder; a byte with a bad stop bit is queued as X.
  logic [7:0] replyQ[$];

  always begin : txMon
    logic [7:0] b;
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BIT) @(negedge clk);
      if (uart_tx === 1'b1) replyQ.push_back(b);
      else                  replyQ.push_back(8'hxx);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectReply(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = 8'hxx;
    for (int n = 0; n < 4000; n++) begin
      if (replyQ.size() != 0) break;
      @(negedge clk);
    end
    if (replyQ.size() != 0) b = replyQ.pop_front();
    checkOutput(tag, {24'h0, b}, {24'h0, exp});
  endtask

  int base, baseU;

  initial begin
    repeat (5) @(negedge clk);
    checkOutput("rst_tx",   32'(uart_tx), 32'd1);
    checkOutput("rst_en",   32'(peripheralEnable), 32'd0);
    checkOutput("rst_we",   32'(peripheralBus_we), 32'd0);
    checkOutput("rst_oe",   32'(peripheralBus_oe), 32'd0);
    checkOutput("rst_addr", 32'(peripheralBus_address), 32'd0);
    checkOutput("rst_bsel", 32'(peripheralBus_byteSelect), 32'd0);
    checkOutput("rst_dw",   peripheralBus_dataWrite, 32'd0);
    checkOutput("rst_act",  32'(active), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] write 0xDEADBEEF to 0x1234");
    base = accCycles;
    applyStimulus(8'h8F); applyStimulus(8'h12); applyStimulus(8'h34);
    applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
    expectReply("wr_ack", 8'h06);
    checkOutput("wr_len",  32'(lastLen), 32'd1);
    checkOutput("wr_acc",  32'(accCycles - base), 32'd1);
    checkOutput("wr_we",   32'(capWe), 32'd1);
    checkOutput("wr_oe",   32'(capOe), 32'd0);
    checkOutput("wr_addr", 32'(capAddr), 32'h1234);
    checkOutput("wr_bsel", 32'(capBsel), 32'hF);
    checkOutput("wr_dw",   capDw, 32'hDEADBEEF);
    repeat (24) @(negedge clk);
    checkOutput("wr_idle", 32'(active), 32'd0);

    $display("[TB] single-cycle read from 0x0008");
    rdData = 32'h0000002A;
    busyHold = 0;
    applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h08);
    expectReply("rd_b3", 8'h00); expectReply("rd_b2", 8'h00);
    expectReply("rd_b1", 8'h00); expectReply("rd_b0", 8'h2A);
    checkOutput("rd_len",  32'(lastLen), 32'd1);
    checkOutput("rd_oe",   32'(capOe), 32'd1);
    checkOutput("rd_we",   32'(capWe), 32'd0);
    checkOutput("rd_addr", 32'(capAddr), 32'h0008);
    checkOutput("rd_bsel", 32'(capBsel), 32'h3);
    repeat (24) @(negedge clk);

    $display("[TB] read with busy held 5 cycles");
    rdData = 32'h12345678;
    busyHold = 5;
    baseU = unstable;
    applyStimulus(8'h0F); applyStimulus(8'hAB); applyStimulus(8'hCD);
    expectReply("bs_b3", 8'h12); expectReply("bs_b2", 8'h34);
    expectReply("bs_b1", 8'h56); expectReply("bs_b0", 8'h78);
    checkOutput("bs_len",    32'(lastLen), 32'd6);
    checkOutput("bs_stable", 32'(unstable - baseU), 32'd0);
    checkOutput("bs_addr",   32'(capAddr), 32'hABCD);
    busyHold = 0;
    repeat (24) @(negedge clk);

    $display("[TB] bus timeout with busy stuck high");
    busyForce = 1'b1;
    applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h10);
    expectReply("to_nak", 8'h15);
    checkOutput("to_len",     32'(lastLen), 32'd1024);
    checkOutput("to_en",      32'(peripheralEnable), 32'd0);
    checkOutput("to_act_mid", 32'(active), 32'd1);
    repeat (24) @(negedge clk);
    checkOutput("to_act_end", 32'(active), 32'd0);
    busyForce = 1'b0;

    $display("[TB] bad command byte 0x70");
    base = accCycles;
    applyStimulus(8'h70);
    expectReply("bad_nak", 8'h15);
    checkOutput("bad_noacc", 32'(accCycles - base), 32'd0);
    repeat (24) @(negedge clk);

    $display("[TB] truncated write frame left to time out");
    base = accCycles;
    applyStimulus(8'h8F); applyStimulus(8'h12);
    repeat (3500) @(negedge clk);
    checkOutput("ft_noacc",   32'(accCycles - base), 32'd0);
    checkOutput("ft_act",     32'(active), 32'd0);
    checkOutput("ft_noreply", 32'(replyQ.size()), 32'd0);

    rdData = 32'hA5A50001;
    applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h08);
    expectReply("ft_rd_b3", 8'hA5); expectReply("ft_rd_b2", 8'hA5);
    expectReply("ft_rd_b1", 8'h00); expectReply("ft_rd_b0", 8'h01);
    checkOutput("ft_rd_acc", 32'(accCycles - base), 32'd1);
    repeat (24) @(negedge clk);

    $display("[TB] reset asserted mid-access");
    busyForce = 1'b1;
    applyStimulus(8'h0F); applyStimulus(8'h00); applyStimulus(8'h20);
    for (int n = 0; n < 400; n++) begin
      if (peripheralEnable) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkOutput("rma_pre_en", 32'(peripheralEnable), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rma_en",   32'(peripheralEnable), 32'd0);
    checkOutput("rma_oe",   32'(peripheralBus_oe), 32'd0);
    checkOutput("rma_addr", 32'(peripheralBus_address), 32'd0);
    checkOutput("rma_bsel", 32'(peripheralBus_byteSelect), 32'd0);
    checkOutput("rma_tx",   32'(uart_tx), 32'd1);
    checkOutput("rma_act",  32'(active), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    busyForce = 1'b0;
    repeat (5) @(negedge clk);

    rdData = 32'h0BADF00D;
    applyStimulus(8'h0C); applyStimulus(8'h00); applyStimulus(8'h40);
    expectReply("rr_b3", 8'h0B); expectReply("rr_b2", 8'hAD);
    expectReply("rr_b1", 8'hF0); expectReply("rr_b0", 8'h0D);
    checkOutput("rr_bsel", 32'(capBsel), 32'hC);
    checkOutput("rr_addr", 32'(capAddr), 32'h0040);
    repeat (24) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
